data_end_checker: RTL

- Synthesizable, cycle-accurate hardware checker for the data-phase termination rule on the mclk target bus.
- Rule: after `data_phase` rises, within MIN_DLY..MAX_DLY cycles a sample must show `irdy==0` together with a falling edge of either `trdy` or `stop`.
- Sits directly downstream of the target data-phase sequencer that drives `data_phase`, `trdy` and `stop`, and watches the same wires.
- Reports per-attempt pass/fail pulses, saturating counters and a sticky error flag for emulation/FPGA builds where SVA is unavailable.

---
 rtl/data_end_checker_if.sv | 28 ++
 rtl/data_end_checker.sv | 103 ++++++++++
 2 files changed

// File: rtl/data_end_checker_if.sv
// Bundle of the monitored target-bus wires plus the checker's result outputs.
// The sequencer/bench side drives the monitored wires; the checker side drives the results.
interface data_end_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             en;
  logic             clr;
  logic             data_phase;
  logic             irdy;
  logic             trdy;
  logic             stop;
  logic             pass_o;
  logic             fail_o;
  logic             active_o;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             err_sticky;

  modport master (
    output en, clr, data_phase, irdy, trdy, stop,
    input  pass_o, fail_o, active_o, pass_cnt, fail_cnt, err_sticky
  );

  modport slave (
    input  en, clr, data_phase, irdy, trdy, stop,
    output pass_o, fail_o, active_o, pass_cnt, fail_cnt, err_sticky
  );
endinterface

// File: rtl/data_end_checker.sv
// Data-phase termination checker: after data_phase rises, irdy==0 with a trdy/stop fall
// must be seen within MIN_DLY..MAX_DLY samples. Reports pulses, saturating counters, sticky error.
module data_end_checker #(
  parameter int unsigned MIN_DLY = 1,
  parameter int unsigned MAX_DLY = 5,
  parameter int unsigned CNT_W   = 16
) (
  input logic               mclk,
  input logic               rst_n,
  data_end_checker_if.slave bus
);
  localparam int unsigned PC_W = $clog2(MAX_DLY + 1);

  logic               r_prev_dp;
  logic               r_prev_trdy;
  logic               r_prev_stop;
  logic               r_primed;
  logic [MAX_DLY:1]   r_p;
  logic               r_pass;
  logic               r_fail;
  logic               r_active;
  logic               r_err;
  logic [CNT_W-1:0]   r_pass_cnt;
  logic [CNT_W-1:0]   r_fail_cnt;

  logic               w_rose;
  logic               w_fell_t;
  logic               w_fell_s;
  logic               w_match;
  logic               w_expired;
  logic [MAX_DLY:1]   w_mask;
  logic [MAX_DLY:1]   w_resolved;
  logic [MAX_DLY:1]   w_next_p;
  logic [PC_W-1:0]    w_npass;
  logic [CNT_W+PC_W-1:0] w_pass_sum;
  logic [CNT_W:0]     w_fail_sum;

  always_comb begin
    w_rose   = r_primed & bus.data_phase & ~r_prev_dp;
    w_fell_t = r_primed & ~bus.trdy & r_prev_trdy;
    w_fell_s = r_primed & ~bus.stop & r_prev_stop;
    w_match  = ~bus.irdy & (w_fell_t | w_fell_s);

    w_mask = '0;
    for (int unsigned k = MIN_DLY; k <= MAX_DLY; k++) w_mask[k] = 1'b1;

    w_resolved = w_match ? (r_p & w_mask) : '0;
    w_expired  = r_p[MAX_DLY] & ~w_match;

    w_npass = '0;
    for (int unsigned k = 1; k <= MAX_DLY; k++) w_npass = w_npass + PC_W'(w_resolved[k]);

    // Resolved slots are cleared before the shift; the oldest slot falls off the top.
    w_next_p    = '0;
    w_next_p[1] = w_rose & bus.en;
    for (int unsigned k = 2; k <= MAX_DLY; k++) w_next_p[k] = r_p[k-1] & ~w_resolved[k-1];

    w_pass_sum = (CNT_W+PC_W)'(r_pass_cnt) + (CNT_W+PC_W)'(w_npass);
    w_fail_sum = (CNT_W+1)'(r_fail_cnt) + (CNT_W+1)'(w_expired);
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      r_prev_dp   <= 1'b0;
      r_prev_trdy <= 1'b0;
      r_prev_stop <= 1'b0;
      r_primed    <= 1'b0;
      r_p         <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_active    <= 1'b0;
      r_err       <= 1'b0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
    end else begin
      r_prev_dp   <= bus.data_phase;
      r_prev_trdy <= bus.trdy;
      r_prev_stop <= bus.stop;
      r_primed    <= 1'b1;
      r_p         <= w_next_p;
      r_pass      <= |w_resolved;
      r_fail      <= w_expired;
      r_active    <= |w_next_p;
      // clr takes priority over a same-cycle expiry for counters and sticky flag only.
      if (bus.clr) begin
        r_pass_cnt <= '0;
        r_fail_cnt <= '0;
        r_err      <= 1'b0;
      end else begin
        r_pass_cnt <= (|w_pass_sum[CNT_W+PC_W-1:CNT_W]) ? '1 : w_pass_sum[CNT_W-1:0];
        r_fail_cnt <= w_fail_sum[CNT_W] ? '1 : w_fail_sum[CNT_W-1:0];
        r_err      <= r_err | w_expired;
      end
    end
  end

  assign bus.pass_o     = r_pass;
  assign bus.fail_o     = r_fail;
  assign bus.active_o   = r_active;
  assign bus.pass_cnt   = r_pass_cnt;
  assign bus.fail_cnt   = r_fail_cnt;
  assign bus.err_sticky = r_err;
endmodule
